// File: rtl/digi_ota_pkg.sv
// Shared types for the clocked multi-channel digital OTA array.
// Channel state, operating-mode encodings and the candidate-state rule.
package digi_ota_pkg;

    typedef enum logic [1:0] {
        HIZ = 2'd0,
        SRC = 2'd1,
        SNK = 2'd2
    } ota_state_t;

    localparam logic [1:0] MODE_OTA = 2'd0;
    localparam logic [1:0] MODE_CMP = 2'd1;
    localparam logic [1:0] MODE_DIS = 2'd2;
    localparam logic [1:0] MODE_INV = 2'd3;

    // Equal inputs release the output, except in comparator mode where the last decision holds.
    function automatic ota_state_t cand_state(input logic sp, input logic sn,
                                              input logic [1:0] mode, input ota_state_t cur);
        ota_state_t c;
        c = HIZ;
        if (sp && !sn)
            c = SRC;
        else if (!sp && sn)
            c = SNK;
        else if (mode == MODE_CMP)
            c = cur;
        return c;
    endfunction

endpackage

// File: rtl/digi_ota_chan.sv
// One OTA channel: input synchroniser, glitch filter, HIZ/SRC/SNK FSM and
// registered drive outputs with a one-cycle state-change pulse.
module digi_ota_chan
    import digi_ota_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 3,
    parameter int GM_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              vip,
    input  logic              vin,
    input  logic [1:0]        mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [GM_W-1:0]   gm,
    input  logic [GM_W-1:0]   phase,
    output logic              out,
    output logic              out_oe,
    output logic              trans
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic [SYNC_STAGES-1:0] sync_n;
    logic                   sp;
    logic                   sn;
    logic                   force_hiz;

    ota_state_t             state;
    ota_state_t             state_next;
    ota_state_t             cand;
    ota_state_t             prev_cand;

    logic [FILT_W-1:0]      cnt;
    logic [FILT_W-1:0]      cnt_eff;
    logic [FILT_W-1:0]      cnt_next;

    logic                   chg;
    logic                   out_d;
    logic                   oe_d;
    logic                   trans_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
            sync_n <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], vip};
            sync_n <= {sync_n[SYNC_STAGES-2:0], vin};
        end
    end

    assign sp        = sync_p[SYNC_STAGES-1];
    assign sn        = sync_n[SYNC_STAGES-1];
    assign force_hiz = !ena || (mode == MODE_DIS);
    assign cand      = cand_state(sp, sn, mode, state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HIZ;
            cnt       <= '0;
            prev_cand <= HIZ;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            prev_cand <= force_hiz ? HIZ : cand;
        end
    end

    // A candidate that just changed restarts its stability count from zero.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        cnt_eff    = (cand == prev_cand) ? cnt : '0;
        if (force_hiz) begin
            state_next = HIZ;
        end else if (cand != state) begin
            if (cnt_eff >= filt_len)
                state_next = cand;
            else
                cnt_next = cnt_eff + FILT_W'(1);
        end
    end

    // Disable bypasses the normal output pipeline so the release shows after one edge.
    always_comb begin
        oe_d    = 1'b0;
        out_d   = out;
        trans_d = chg;
        if (force_hiz) begin
            trans_d = chg || (state != HIZ);
        end else if (state != HIZ) begin
            oe_d  = (&gm) || (phase < gm);
            out_d = (state == SRC) ^ (mode == MODE_INV);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg    <= 1'b0;
            out    <= 1'b0;
            out_oe <= 1'b0;
            trans  <= 1'b0;
        end else begin
            chg    <= !force_hiz && (state_next != state);
            out    <= out_d;
            out_oe <= oe_d;
            trans  <= trans_d;
        end
    end

endmodule

// File: rtl/digi_ota_array.sv
// Multi-channel clocked digital OTA: a shared drive-duty phase counter
// feeding CHANNELS independent OTA channels.
module digi_ota_array
    import digi_ota_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 3,
    parameter int GM_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] vip,
    input  logic [CHANNELS-1:0] vin,
    input  logic [1:0]          mode,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic [GM_W-1:0]     gm,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] out_oe,
    output logic [CHANNELS-1:0] trans
);

    logic [GM_W-1:0] phase;

    // Phase restarts from zero whenever the block is idle so duty windows line up on wake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (!ena || (mode == MODE_DIS))
            phase <= '0;
        else
            phase <= phase + GM_W'(1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        digi_ota_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .GM_W        (GM_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .vip      (vip[i]),
            .vin      (vin[i]),
            .mode     (mode),
            .filt_len (filt_len),
            .gm       (gm),
            .phase    (phase),
            .out      (out[i]),
            .out_oe   (out_oe[i]),
            .trans    (trans[i])
        );
    end

endmodule

// File: tb/tb_digi_ota_array.sv
// Directed and randomized bench for digi_ota_array against a cycle-level
// behavioural model of the channel rules.
module tb_digi_ota_array;

    localparam int CH = 2;
    localparam int S  = 2;
    localparam int FW = 3;
    localparam int GW = 4;

    localparam int ST_HIZ = 0;
    localparam int ST_SRC = 1;
    localparam int ST_SNK = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [CH-1:0] vip;
    logic [CH-1:0] vin;
    logic [1:0]    mode;
    logic [FW-1:0] filt_len;
    logic [GW-1:0] gm;
    logic [CH-1:0] out;
    logic [CH-1:0] out_oe;
    logic [CH-1:0] trans;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [S-1:0]  m_hp [CH];
    logic [S-1:0]  m_hn [CH];
    int            m_state [CH];
    int            m_run [CH];
    int            m_last [CH];
    logic [CH-1:0] m_out = '0;
    logic [CH-1:0] m_oe = '0;
    logic [CH-1:0] m_trans = '0;
    logic [CH-1:0] m_chg = '0;
    int            m_phase = 0;

    digi_ota_array #(
        .CHANNELS    (CH),
        .SYNC_STAGES (S),
        .FILT_W      (FW),
        .GM_W        (GW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .vip      (vip),
        .vin      (vin),
        .mode     (mode),
        .filt_len (filt_len),
        .gm       (gm),
        .out      (out),
        .out_oe   (out_oe),
        .trans    (trans)
    );

    always #5 clk = ~clk;

    task automatic mdlReset();
        for (int c = 0; c < CH; c++) begin
            m_hp[c]    = '0;
            m_hn[c]    = '0;
            m_state[c] = ST_HIZ;
            m_run[c]   = 0;
            m_last[c]  = ST_HIZ;
        end
        m_out   = '0;
        m_oe    = '0;
        m_trans = '0;
        m_chg   = '0;
        m_phase = 0;
    endtask

    task automatic mdlStep();
        bit idle;
        int cand;
        int old;
        int nxt;
        logic p;
        logic n;
        idle = !ena || (mode == 2'd2);
        for (int c = 0; c < CH; c++) begin
            p = m_hp[c][S-1];
            n = m_hn[c][S-1];
            if (p && !n)       cand = ST_SRC;
            else if (!p && n)  cand = ST_SNK;
            else if (mode == 2'd1) cand = m_state[c];
            else               cand = ST_HIZ;
            old = m_state[c];
            if (idle) begin
                m_trans[c] = m_chg[c] || (old != ST_HIZ);
                m_oe[c]    = 1'b0;
                m_chg[c]   = 1'b0;
                m_state[c] = ST_HIZ;
                m_run[c]   = 0;
                m_last[c]  = ST_HIZ;
            end else begin
                m_run[c]  = (cand == m_last[c]) ? m_run[c] + 1 : 1;
                m_last[c] = cand;
                nxt = (cand != old && m_run[c] >= int'(filt_len) + 1) ? cand : old;
                m_trans[c] = m_chg[c];
                m_oe[c]    = (old != ST_HIZ) && (gm == 4'hF || m_phase < int'(gm));
                if (old != ST_HIZ)
                    m_out[c] = (old == ST_SRC) ^ (mode == 2'd3);
                m_chg[c]   = (nxt != old);
                m_state[c] = nxt;
            end
            m_hp[c] = {m_hp[c][S-2:0], vip[c]};
            m_hn[c] = {m_hn[c][S-2:0], vin[c]};
        end
        m_phase = idle ? 0 : (m_phase + 1) % 16;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdlReset();
        else        mdlStep();
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("model out", 32'(out), 32'(m_out));
        checkVal("model out_oe", 32'(out_oe), 32'(m_oe));
        checkVal("model trans", 32'(trans), 32'(m_trans));
    endtask

    task automatic applyStimulus(input logic [CH-1:0] p, input logic [CH-1:0] n);
        vip = p;
        vin = n;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int oe_cnt;
        int hold;
        rst_n    = 1'b0;
        ena      = 1'b1;
        mode     = 2'd0;
        filt_len = '0;
        gm       = 4'hF;
        applyStimulus('1, '0);
        ticks(3);
        checkVal("reset out", 32'(out), 0);
        checkVal("reset out_oe", 32'(out_oe), 0);
        checkVal("reset trans", 32'(trans), 0);

        // Basic OTA latency on channel 0
        applyStimulus('0, '0);
        rst_n = 1'b1;
        ticks(4);
        applyStimulus(2'b01, 2'b00);
        ticks(3);
        checkVal("lat oe early", 32'(out_oe[0]), 0);
        checkVal("lat trans early", 32'(trans[0]), 0);
        tick();
        checkVal("lat out", 32'(out[0]), 1);
        checkVal("lat oe", 32'(out_oe[0]), 1);
        checkVal("lat trans", 32'(trans[0]), 1);
        checkVal("ch1 untouched", 32'(out_oe[1]), 0);
        tick();
        checkVal("trans one cycle", 32'(trans[0]), 0);
        applyStimulus(2'b01, 2'b01);
        ticks(3);
        checkVal("release early", 32'(out_oe[0]), 1);
        tick();
        checkVal("release oe", 32'(out_oe[0]), 0);
        checkVal("release trans", 32'(trans[0]), 1);

        // Glitch filter
        applyStimulus('0, '0);
        ticks(6);
        filt_len = 3'd3;
        applyStimulus(2'b01, 2'b00);
        ticks(3);
        applyStimulus('0, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkVal("glitch oe", 32'(out_oe[0]), 0);
            checkVal("glitch trans", 32'(trans[0]), 0);
        end
        applyStimulus(2'b01, 2'b00);
        ticks(6);
        checkVal("filt oe early", 32'(out_oe[0]), 0);
        tick();
        checkVal("filt oe", 32'(out_oe[0]), 1);
        checkVal("filt trans", 32'(trans[0]), 1);

        // Duty cycling with SRC steady
        filt_len = '0;
        gm = 4'd4;
        oe_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            oe_cnt += int'(out_oe[0]);
            checkVal("duty out", 32'(out[0]), 1);
        end
        checkVal("duty gm4", 32'(oe_cnt), 4);
        gm = 4'd0;
        oe_cnt = 0;
        for (int i = 0; i < 16; i++) begin tick(); oe_cnt += int'(out_oe[0]); end
        checkVal("duty gm0", 32'(oe_cnt), 0);
        gm = 4'hF;
        oe_cnt = 0;
        for (int i = 0; i < 16; i++) begin tick(); oe_cnt += int'(out_oe[0]); end
        checkVal("duty gm15", 32'(oe_cnt), 16);

        // Comparator holds on equal inputs
        mode = 2'd1;
        tick();
        applyStimulus(2'b01, 2'b01);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal("cmp oe", 32'(out_oe[0]), 1);
            checkVal("cmp out", 32'(out[0]), 1);
            checkVal("cmp trans", 32'(trans[0]), 0);
        end
        applyStimulus(2'b01, 2'b00);
        mode = 2'd0;
        ticks(4);
        applyStimulus(2'b01, 2'b01);
        ticks(3);
        checkVal("ota eq early", 32'(out_oe[0]), 1);
        tick();
        checkVal("ota eq oe", 32'(out_oe[0]), 0);

        // Invert, disable and ena release
        mode = 2'd3;
        applyStimulus(2'b01, 2'b00);
        ticks(5);
        checkVal("inv out", 32'(out[0]), 0);
        checkVal("inv oe", 32'(out_oe[0]), 1);
        mode = 2'd2;
        tick();
        checkVal("dis oe", 32'(out_oe[0]), 0);
        checkVal("dis trans", 32'(trans[0]), 1);
        mode = 2'd3;
        ticks(6);
        checkVal("inv again oe", 32'(out_oe[0]), 1);
        ena = 1'b0;
        tick();
        checkVal("ena oe", 32'(out_oe[0]), 0);
        checkVal("ena trans", 32'(trans[0]), 1);
        ena = 1'b1;

        // Randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            applyStimulus(CH'($urandom), CH'($urandom));
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) gm = GW'($urandom);
            if ($urandom_range(0, 5) == 0) filt_len = FW'($urandom_range(0, 3));
            ena = ($urandom_range(0, 9) != 0);
            hold = $urandom_range(1, 8);
            ticks(hold);
        end

        // Asynchronous reset while driving
        ena = 1'b1;
        mode = 2'd0;
        gm = 4'hF;
        filt_len = '0;
        applyStimulus('1, '0);
        ticks(8);
        checkVal("pre-reset oe", 32'(out_oe), 32'(2'b11));
        #1 rst_n = 1'b0;
        #1;
        checkVal("async rst oe", 32'(out_oe), 0);
        checkVal("async rst out", 32'(out), 0);
        checkVal("async rst trans", 32'(trans), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        checkVal("post-reset early", 32'(out_oe), 0);
        tick();
        checkVal("post-reset oe", 32'(out_oe), 32'(2'b11));
        checkVal("post-reset trans", 32'(trans), 32'(2'b11));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
